// File: rtl/dongwon_assoc_cache_if.sv
// CPU-side and memory-side bus of dongwon_assoc_cache.
// The cache connects through the slave modport; the CPU/memory environment uses master.
interface dongwon_assoc_cache_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  flush;
  logic                  ready;
  logic                  done;
  logic [DATA_WIDTH-1:0] out_data;
  logic [2:0]            state_of_cache;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req, we, addr, in_data, flush, mem_ack, mem_rdata,
    output ready, done, out_data, state_of_cache,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, in_data, flush, mem_ack, mem_rdata,
    input  ready, done, out_data, state_of_cache,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dongwon_assoc_cache.sv
// N-way set-associative write-through read cache with round-robin replacement and flush.
// Define DONGWON_CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module dongwon_assoc_cache #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CACHE_SIZE = 64,
  parameter int WAYS       = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  dongwon_assoc_cache_if.slave bus
`ifdef DONGWON_CACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
`endif
);

  localparam int SETS  = CACHE_SIZE / WAYS;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    WRITE     = 3'b010,
    READ_MISS = 3'b100,
    READ_HIT  = 3'b101,
    FILL      = 3'b110
  } state_t;

  state_t state, state_next;

  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAY_W-1:0]      rr_q    [SETS];
  logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  hit_q;
  logic [WAY_W-1:0]      hit_way_q;
  logic [DATA_WIDTH-1:0] rsp_q;

  logic [IDX_W-1:0]      lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic                  lk_hit;
  logic [WAY_W-1:0]      lk_way;
  logic [DATA_WIDTH-1:0] lk_data;

  logic [IDX_W-1:0]      cur_idx;
  logic [TAG_W-1:0]      cur_tag;
  logic [WAY_W-1:0]      victim;
  logic [WAY_W-1:0]      rr_next;

  logic                  accept;
  logic                  flush_now;
  logic                  fill_now;
  logic                  write_now;

  assign lk_idx  = bus.addr[2 +: IDX_W];
  assign lk_tag  = bus.addr[ADDR_WIDTH-1 -: TAG_W];
  assign cur_idx = addr_q[2 +: IDX_W];
  assign cur_tag = addr_q[ADDR_WIDTH-1 -: TAG_W];

  assign bus.ready          = (state == IDLE) && !bus.flush;
  assign bus.state_of_cache = state;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wdata      = wdata_q;

  assign accept    = bus.req && bus.ready;
  assign flush_now = bus.flush && (state == IDLE);
  assign fill_now  = (state == READ_MISS) && bus.mem_ack;
  assign write_now = (state == WRITE) && bus.mem_ack;

  // Tag compare across the addressed set; scanning downward lets the lowest matching way win.
  always_comb begin
    lk_hit  = 1'b0;
    lk_way  = '0;
    lk_data = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lk_hit  = 1'b1;
        lk_way  = WAY_W'(w);
        lk_data = data_q[lk_idx][w];
      end
    end
  end

  // Victim is the lowest invalid way, falling back to the set's round-robin pointer.
  always_comb begin
    victim = rr_q[cur_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[cur_idx][w]) begin
        victim = WAY_W'(w);
      end
    end
    rr_next = (rr_q[cur_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[cur_idx] + 1'b1;
  end

  always_comb begin
    state_next   = state;
    bus.done     = 1'b0;
    bus.out_data = '0;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.we) begin
            state_next = WRITE;
          end else if (lk_hit) begin
            state_next = READ_HIT;
          end else begin
            state_next = READ_MISS;
          end
        end
      end
      READ_HIT: begin
        bus.done     = 1'b1;
        bus.out_data = rsp_q;
        state_next   = IDLE;
      end
      READ_MISS: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          state_next = FILL;
        end
      end
      FILL: begin
        bus.done     = 1'b1;
        bus.out_data = rsp_q;
        state_next   = IDLE;
      end
      WRITE: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        if (bus.mem_ack) begin
          bus.done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Transaction registers: request captured at acceptance, response word at lookup or at fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      hit_q     <= 1'b0;
      hit_way_q <= '0;
      rsp_q     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q    <= bus.addr;
        wdata_q   <= bus.in_data;
        hit_q     <= lk_hit;
        hit_way_q <= lk_way;
        rsp_q     <= lk_data;
      end
      if (fill_now) begin
        rsp_q <= bus.mem_rdata;
      end
    end
  end

  // Flush clears valid bits only; round-robin pointers keep their history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (flush_now) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
      end
    end else if (fill_now) begin
      valid_q[cur_idx][victim] <= 1'b1;
      rr_q[cur_idx]            <= rr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_now) begin
      tag_q[cur_idx][victim]  <= cur_tag;
      data_q[cur_idx][victim] <= bus.mem_rdata;
    end
    if (write_now && hit_q) begin
      data_q[cur_idx][hit_way_q] <= wdata_q;
    end
  end

`ifdef DONGWON_CACHE_STATS_EN
  // Counters advance on entry into READ_HIT / READ_MISS and stick at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if ((state == IDLE) && (state_next == READ_HIT) && (hit_cnt != 32'hFFFF_FFFF)) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if ((state == IDLE) && (state_next == READ_MISS) && (miss_cnt != 32'hFFFF_FFFF)) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dongwon_assoc_cache.sv
// Directed scoreboard bench for dongwon_assoc_cache (WAYS=2, CACHE_SIZE=64, 32-bit).
// Build with DONGWON_CACHE_STATS_EN defined to also check the hit/miss counters.
module tb_dongwon_assoc_cache;

  logic clk;
  logic reset;

  dongwon_assoc_cache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef DONGWON_CACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  dongwon_assoc_cache #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .CACHE_SIZE(64),
    .WAYS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef DONGWON_CACHE_STATS_EN
    ,
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  typedef struct packed {
    logic        is_read;
    logic [31:0] data;
    logic [2:0]  st;
    logic [7:0]  reqc;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];

  int checks = 0;
  int failures = 0;
  int done_count = 0;

  logic [31:0] mem_model [1024];
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Memory model: acks on the third cycle of a held mem_req, write-through updates the array.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    last_wr_addr  = '0;
    last_wr_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        wait_cnt      = 0;
      end else if (bus.mem_req) begin
        wait_cnt++;
        if (wait_cnt == 3) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) begin
            mem_model[bus.mem_addr[11:2]] = bus.mem_wdata;
            last_wr_addr = bus.mem_addr;
            last_wr_data = bus.mem_wdata;
          end else begin
            bus.mem_rdata = mem_model[bus.mem_addr[11:2]];
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever done is presented.
  initial begin
    int       req_cycles;
    logic [2:0] first_state;
    exp_t     e;
    string    n;
    req_cycles  = 0;
    first_state = 3'b000;
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        req_cycles  = 0;
        first_state = 3'b000;
      end else begin
        if (bus.mem_req) req_cycles++;
        if ((bus.state_of_cache != 3'b000) && (first_state == 3'b000)) first_state = bus.state_of_cache;
        if (bus.done) begin
          done_count++;
          if (sb.size() == 0) begin
            checkOutput("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            n = sb_name.pop_front();
            if (e.is_read) checkOutput({n, "_data"}, bus.out_data, e.data);
            checkOutput({n, "_state"}, {29'd0, first_state}, {29'd0, e.st});
            checkOutput({n, "_memreq_cycles"}, req_cycles, {24'd0, e.reqc});
          end
          req_cycles  = 0;
          first_state = 3'b000;
        end
      end
    end
  end

  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] exp_data, input logic [2:0] exp_state,
                               input int exp_reqc, input string name);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!bus.ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.ready) begin
      checkOutput({name, "_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    bus.req     = 1'b1;
    bus.we      = w;
    bus.addr    = a;
    bus.in_data = d;
    e.is_read   = !w;
    e.data      = exp_data;
    e.st        = exp_state;
    e.reqc      = 8'(exp_reqc);
    sb.push_back(e);
    sb_name.push_back(name);
    @(negedge clk);
    bus.req = 1'b0;
    bus.we  = 1'b0;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      checkOutput({name, "_done_timeout"}, 32'd0, 32'd1);
      sb.delete();
      sb_name.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dc;
    int guard;
    for (int i = 0; i < 1024; i++) mem_model[i] = 32'h0;
    mem_model[10'h000] = 32'h11;
    mem_model[10'h020] = 32'h22;
    mem_model[10'h040] = 32'h33;
    mem_model[10'h080] = 32'h44;

    reset       = 1'b1;
    bus.req     = 1'b0;
    bus.we      = 1'b0;
    bus.addr    = '0;
    bus.in_data = '0;
    bus.flush   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_ready", {31'd0, bus.ready}, 32'd1);
    checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
    checkOutput("rst_state", {29'd0, bus.state_of_cache}, 32'd0);
    checkOutput("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
    checkOutput("rst_out_data", bus.out_data, 32'd0);

    applyStimulus(1'b0, 32'h000, 32'h0, 32'h11, 3'b100, 3, "t1_miss_000");
    applyStimulus(1'b0, 32'h000, 32'h0, 32'h11, 3'b101, 0, "t1_hit_000");
`ifdef DONGWON_CACHE_STATS_EN
    checkOutput("t6_hit_cnt", hit_cnt, 32'd1);
    checkOutput("t6_miss_cnt", miss_cnt, 32'd1);
`endif

    applyStimulus(1'b0, 32'h080, 32'h0, 32'h22, 3'b100, 3, "t2_miss_080");
    applyStimulus(1'b0, 32'h100, 32'h0, 32'h33, 3'b100, 3, "t2_miss_100_evict");
    applyStimulus(1'b0, 32'h080, 32'h0, 32'h22, 3'b101, 0, "t2_hit_080");

    applyStimulus(1'b1, 32'h080, 32'hDEAD, 32'h0, 3'b010, 3, "t3_write_hit_080");
    checkOutput("t3_mem_wr_addr", last_wr_addr, 32'h080);
    checkOutput("t3_mem_wr_data", last_wr_data, 32'hDEAD);
    applyStimulus(1'b0, 32'h080, 32'h0, 32'hDEAD, 3'b101, 0, "t3_hit_080_dead");
    applyStimulus(1'b0, 32'h000, 32'h0, 32'h11, 3'b100, 3, "t2_miss_000_evicted");
    applyStimulus(1'b1, 32'h200, 32'h55, 32'h0, 3'b010, 3, "t3_write_miss_200");
    applyStimulus(1'b0, 32'h200, 32'h0, 32'h55, 3'b100, 3, "t3_miss_200_noalloc");

    applyStimulus(1'b0, 32'h000, 32'h0, 32'h11, 3'b101, 0, "t4_hit_000_preflush");
    @(negedge clk);
    bus.flush = 1'b1;
    #1;
    checkOutput("t4_flush_ready", {31'd0, bus.ready}, 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
`ifdef DONGWON_CACHE_STATS_EN
    checkOutput("t6_flush_hit_cnt", hit_cnt, 32'd4);
    checkOutput("t6_flush_miss_cnt", miss_cnt, 32'd5);
`endif
    applyStimulus(1'b0, 32'h000, 32'h0, 32'h11, 3'b100, 3, "t4_miss_000_postflush");

    dc = done_count;
    @(negedge clk);
    bus.flush = 1'b1;
    bus.req   = 1'b1;
    bus.addr  = 32'h000;
    #1;
    checkOutput("t4_flushreq_ready", {31'd0, bus.ready}, 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.req   = 1'b0;
    #1;
    checkOutput("t4_flushreq_state", {29'd0, bus.state_of_cache}, 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("t4_flushreq_no_done", done_count, dc);

    @(negedge clk);
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 32'h100;
    @(negedge clk);
    bus.req = 1'b0;
    guard = 0;
    while (bus.state_of_cache != 3'b100 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("t5_in_read_miss", {29'd0, bus.state_of_cache}, 32'h4);
    dc = done_count;
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t5_rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("t5_rst_state", {29'd0, bus.state_of_cache}, 32'd0);
    checkOutput("t5_rst_done", {31'd0, bus.done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t5_no_done", done_count, dc);
    applyStimulus(1'b0, 32'h100, 32'h0, 32'h33, 3'b100, 3, "t5_miss_100_after_rst");
`ifdef DONGWON_CACHE_STATS_EN
    checkOutput("t6_rst_hit_cnt", hit_cnt, 32'd0);
    checkOutput("t6_rst_miss_cnt", miss_cnt, 32'd1);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
